// File: rtl/sram_port_arbiter.sv
// Round-robin 2:1 arbiter for one SRAM-like port, with in-order owner tracking that routes each response back to the requester that issued it.
// Zero added latency on both paths; backpressure comes from s_addr_ok, and new grants are held off while DEPTH transactions are outstanding.
module sram_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             m0_req,
  input  logic             m0_wr,
  input  logic [1:0]       m0_size,
  input  logic [31:0]      m0_addr,
  input  logic [3:0]       m0_wstrb,
  input  logic [31:0]      m0_wdata,
  output logic             m0_addr_ok,
  output logic             m0_data_ok,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [1:0]       m1_size,
  input  logic [31:0]      m1_addr,
  input  logic [3:0]       m1_wstrb,
  input  logic [31:0]      m1_wdata,
  output logic             m1_addr_ok,
  output logic             m1_data_ok,
  output logic [31:0]      m1_rdata,
  output logic             s_req,
  output logic             s_wr,
  output logic [1:0]       s_size,
  output logic [31:0]      s_addr,
  output logic [3:0]       s_wstrb,
  output logic [31:0]      s_wdata,
  input  logic             s_addr_ok,
  input  logic             s_data_ok,
  input  logic [31:0]      s_rdata,
  output logic [CNT_W-1:0] outstanding,
  output logic             resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic             r_owner;
  logic             r_rr_prio;
  logic             r_resp_err;
  logic [DEPTH-1:0] r_fifo;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_sel;
  logic w_gnt;
  logic w_own_req;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_own_req = r_owner ? m1_req : m0_req;
  assign w_gnt     = (r_state == S_HOLD) ? r_owner : w_sel;

  always_comb begin
    w_sel = r_rr_prio;
    if (m0_req && !m1_req) begin
      w_sel = 1'b0;
    end else if (m1_req && !m0_req) begin
      w_sel = 1'b1;
    end
  end

  // Request is forced low while reset is held so nothing leaks downstream.
  always_comb begin
    w_req = 1'b0;
    if (r_state == S_HOLD) begin
      w_req = w_own_req;
    end else begin
      w_req = (m0_req | m1_req) & ~w_full;
    end
    w_req = w_req & aresetn;
  end

  assign w_push = w_req & s_addr_ok;
  assign w_pop  = aresetn & s_data_ok & ~w_empty;
  assign w_head = r_fifo[r_rptr];

  assign s_req   = w_req;
  assign s_wr    = w_gnt ? m1_wr    : m0_wr;
  assign s_size  = w_gnt ? m1_size  : m0_size;
  assign s_addr  = w_gnt ? m1_addr  : m0_addr;
  assign s_wstrb = w_gnt ? m1_wstrb : m0_wstrb;
  assign s_wdata = w_gnt ? m1_wdata : m0_wdata;

  assign m0_addr_ok = w_push & ~w_gnt;
  assign m1_addr_ok = w_push &  w_gnt;
  assign m0_data_ok = w_pop  & ~w_head;
  assign m1_data_ok = w_pop  &  w_head;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  assign outstanding = r_count;
  assign resp_err    = r_resp_err;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_rr_prio  <= 1'b0;
      r_resp_err <= 1'b0;
      r_fifo     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_gnt;
        r_wptr         <= r_wptr + 1'b1;
        r_rr_prio      <= ~w_gnt;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (s_data_ok && w_empty) begin
        r_resp_err <= 1'b1;
      end
      // An owner that drops its request in HOLD is released without a push.
      case (r_state)
        S_IDLE: begin
          if (w_req && !s_addr_ok) begin
            r_state <= S_HOLD;
            r_owner <= w_sel;
          end
        end
        default: begin
          if (s_addr_ok || !w_own_req) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized checks of sram_port_arbiter against a transaction-level model.
module tb_sram_port_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [CNT_W-1:0] outstanding;
  logic        resp_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  sram_port_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_addr = 0; m0_wstrb = 4'hF; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 2'd2; m1_addr = 0; m1_wstrb = 4'hF; m1_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 0;
    tick();
    aresetn = 1;
  endtask

  // Random-phase model state
  int          q[$];
  int          last_g, locked, g;
  bit          exp_err, es, dk;
  bit          rq[2], got[2], wrr[2];
  logic [31:0] ad[2], wd[2];
  logic [1:0]  sz[2];
  logic [3:0]  st[2];
  int          own[4];

  initial begin
    idle_inputs();
    aresetn = 0;
    // Outputs stay quiet during reset even with every input asserted
    m0_req = 1; m1_req = 1; s_addr_ok = 1; s_data_ok = 1;
    settle();
    chk("rst_s_req", s_req, 0);
    chk("rst_m0_addr_ok", m0_addr_ok, 0);
    chk("rst_m1_addr_ok", m1_addr_ok, 0);
    chk("rst_m0_data_ok", m0_data_ok, 0);
    chk("rst_m1_data_ok", m1_data_ok, 0);
    tick();
    settle();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_resp_err", resp_err, 0);
    tick();

    // Single read: accept in cycle 0, respond in cycle 2
    do_reset();
    m0_req = 1; m0_addr = 32'h1000; s_addr_ok = 1;
    settle();
    chk("t1_s_req", s_req, 1);
    chk("t1_m0_addr_ok", m0_addr_ok, 1);
    chk("t1_m1_addr_ok", m1_addr_ok, 0);
    chk("t1_s_addr", s_addr, 32'h1000);
    tick();
    m0_req = 0; s_addr_ok = 0;
    settle();
    chk("t1_outst_1", outstanding, 1);
    chk("t1_m0_data_ok_early", m0_data_ok, 0);
    tick();
    s_data_ok = 1; s_rdata = 32'hDEADBEEF;
    settle();
    chk("t1_m0_data_ok", m0_data_ok, 1);
    chk("t1_m1_data_ok", m1_data_ok, 0);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    tick();
    s_data_ok = 0;
    settle();
    chk("t1_outst_0", outstanding, 0);
    chk("t1_resp_err", resp_err, 0);
    tick();

    // Alternating grants, then fill to DEPTH and unblock one cycle after a pop
    do_reset();
    m0_req = 1; m0_addr = 32'hA000; m1_req = 1; m1_addr = 32'hB000; s_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t2_m0_addr_ok_%0d", k), m0_addr_ok, (k % 2) == 0);
      chk($sformatf("t2_m1_addr_ok_%0d", k), m1_addr_ok, (k % 2) == 1);
      chk($sformatf("t2_s_addr_%0d", k), s_addr, ((k % 2) == 0) ? 32'hA000 : 32'hB000);
      tick();
    end
    settle();
    chk("t4_full_s_req", s_req, 0);
    chk("t4_full_outst", outstanding, 4);
    chk("t4_full_m0_addr_ok", m0_addr_ok, 0);
    tick();
    s_data_ok = 1; s_rdata = 32'h5555;
    settle();
    chk("t4_pop_s_req", s_req, 0);
    chk("t4_pop_m0_data_ok", m0_data_ok, 1);
    tick();
    s_data_ok = 0;
    settle();
    chk("t4_after_s_req", s_req, 1);
    chk("t4_after_outst", outstanding, 3);
    chk("t4_after_m0_addr_ok", m0_addr_ok, 1);
    tick();

    // Grant held through three stalled cycles while the other side waits
    do_reset();
    m1_req = 1; m1_addr = 32'hC000;
    settle();
    chk("t3_s_addr_0", s_addr, 32'hC000);
    chk("t3_m1_addr_ok_0", m1_addr_ok, 0);
    tick();
    m0_req = 1; m0_addr = 32'hD000;
    for (int k = 1; k < 3; k++) begin
      settle();
      chk($sformatf("t3_s_addr_%0d", k), s_addr, 32'hC000);
      chk($sformatf("t3_m0_addr_ok_%0d", k), m0_addr_ok, 0);
      tick();
    end
    s_addr_ok = 1;
    settle();
    chk("t3_s_addr_3", s_addr, 32'hC000);
    chk("t3_m1_addr_ok_3", m1_addr_ok, 1);
    chk("t3_m0_addr_ok_3", m0_addr_ok, 0);
    tick();
    m1_req = 0;
    settle();
    chk("t3_m0_addr_ok_4", m0_addr_ok, 1);
    chk("t3_s_addr_4", s_addr, 32'hD000);
    tick();

    // Responses follow acceptance order m0, m1, m1, m0
    do_reset();
    own = '{0, 1, 1, 0};
    s_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      m0_req = (own[k] == 0); m1_req = (own[k] == 1);
      settle();
      chk($sformatf("t5_addr_ok_%0d", k), own[k] == 0 ? m0_addr_ok : m1_addr_ok, 1);
      tick();
    end
    m0_req = 0; m1_req = 0; s_addr_ok = 0;
    for (int k = 0; k < 4; k++) begin
      s_data_ok = 1; s_rdata = 32'h100 + k;
      settle();
      chk($sformatf("t5_m0_data_ok_%0d", k), m0_data_ok, own[k] == 0);
      chk($sformatf("t5_m1_data_ok_%0d", k), m1_data_ok, own[k] == 1);
      chk($sformatf("t5_rdata_%0d", k), own[k] == 0 ? m0_rdata : m1_rdata, 32'h100 + k);
      tick();
    end
    s_data_ok = 0;
    settle();
    chk("t5_resp_err", resp_err, 0);
    chk("t5_outst", outstanding, 0);
    tick();

    // Reset while holding a grant with two outstanding
    do_reset();
    s_addr_ok = 1;
    m0_req = 1; tick();
    m0_req = 0; m1_req = 1; tick();
    m0_req = 1; m0_addr = 32'hE000; m1_req = 0; s_addr_ok = 0;
    settle();
    chk("t6_outst_2", outstanding, 2);
    chk("t6_s_req_hold", s_req, 1);
    tick();
    aresetn = 0;
    settle();
    chk("t6_rst_s_req", s_req, 0);
    tick();
    aresetn = 1; m0_req = 0; m1_req = 1; m1_addr = 32'hF000;
    settle();
    chk("t6_outst_0", outstanding, 0);
    chk("t6_idle_s_req", s_req, 1);
    chk("t6_idle_s_addr", s_addr, 32'hF000);
    tick();
    m1_req = 0; s_data_ok = 1;
    settle();
    chk("t6_m0_data_ok", m0_data_ok, 0);
    chk("t6_m1_data_ok", m1_data_ok, 0);
    tick();
    s_data_ok = 0;
    settle();
    chk("t6_resp_err", resp_err, 1);
    tick();

    // Randomized traffic against a transaction-level model
    do_reset();
    q.delete();
    last_g = 1; locked = -1; exp_err = 0;
    rq = '{0, 0}; got = '{0, 0};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] || got[i]) begin
          rq[i]  = ($urandom_range(0, 2) != 0);
          ad[i]  = $urandom; wd[i] = $urandom; wrr[i] = $urandom_range(0, 1);
          sz[i]  = 2'($urandom_range(0, 2)); st[i] = 4'($urandom);
        end
        got[i] = 0;
      end
      m0_req = rq[0]; m0_addr = ad[0]; m0_wdata = wd[0]; m0_wr = wrr[0]; m0_size = sz[0]; m0_wstrb = st[0];
      m1_req = rq[1]; m1_addr = ad[1]; m1_wdata = wd[1]; m1_wr = wrr[1]; m1_size = sz[1]; m1_wstrb = st[1];
      s_addr_ok = $urandom_range(0, 1);
      s_data_ok = ($urandom_range(0, 2) == 0);
      s_rdata   = $urandom;
      settle();
      if (locked >= 0) g = locked;
      else if (rq[0] && rq[1]) g = 1 - last_g;
      else if (rq[1]) g = 1;
      else g = 0;
      es = (locked >= 0) || ((rq[0] || rq[1]) && q.size() < DEPTH);
      chk("rnd_s_req", s_req, es);
      if (es) begin
        chk("rnd_s_addr", s_addr, ad[g]);
        chk("rnd_s_wdata", s_wdata, wd[g]);
        chk("rnd_s_wr", s_wr, wrr[g]);
        chk("rnd_s_size", s_size, sz[g]);
        chk("rnd_s_wstrb", s_wstrb, st[g]);
      end
      chk("rnd_m0_addr_ok", m0_addr_ok, es && s_addr_ok && g == 0);
      chk("rnd_m1_addr_ok", m1_addr_ok, es && s_addr_ok && g == 1);
      dk = s_data_ok && (q.size() > 0);
      chk("rnd_m0_data_ok", m0_data_ok, dk && q[0] == 0);
      chk("rnd_m1_data_ok", m1_data_ok, dk && q[0] == 1);
      chk("rnd_m1_rdata", m1_rdata, s_rdata);
      chk("rnd_outstanding", outstanding, q.size());
      chk("rnd_resp_err", resp_err, exp_err);
      if (s_data_ok && q.size() == 0) exp_err = 1;
      if (dk) void'(q.pop_front());
      if (es && s_addr_ok) begin
        q.push_back(g);
        last_g = g; locked = -1; got[g] = 1;
      end else if (es) begin
        locked = g;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Two-requester arbiter and response router in front of one SRAM-like port of the AXI transfer bridge, normally the data port. Typical requesters are the load/store unit (m0) and the page-table walker or uncached engine (m1). It grants the shared port round-robin and holds the grant until the address handshake completes. It records the owner of every accepted transaction in an in-order owner FIFO and steers each data_ok/rdata back to that owner. The bridge returns responses on a port in request order; this block relies on that.

Parameters:
DEPTH, 4, maximum outstanding accepted transactions (owner FIFO entries); power of two, minimum 2
CNT_W, 3, width of the outstanding counter; equals log2(DEPTH)+1

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
m0_req  in  1  requester 0 request
m0_wr  in  1  requester 0 write (1) / read (0)
m0_size  in  2  requester 0 access size
m0_addr  in  32  requester 0 address
m0_wstrb  in  4  requester 0 byte strobes
m0_wdata  in  32  requester 0 write data
m0_addr_ok  out  1  requester 0 request accepted
m0_data_ok  out  1  requester 0 response valid
m0_rdata  out  32  requester 0 read data
m1_*  same set and directions as m0_*, for requester 1
s_req  out  1  downstream request
s_wr  out  1  downstream write flag
s_size  out  2  downstream size
s_addr  out  32  downstream address
s_wstrb  out  4  downstream strobes
s_wdata  out  32  downstream write data
s_addr_ok  in  1  downstream accepted
s_data_ok  in  1  downstream response
s_rdata  in  32  downstream read data
outstanding  out  CNT_W  current owner FIFO occupancy
resp_err  out  1  sticky: s_data_ok arrived with owner FIFO empty

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is synchronous and active-low.
- Reset values: state=IDLE, rr_prio=0 (m0 preferred), FIFO empty, outstanding=0, resp_err=0.
- Reset outputs: all *_addr_ok, *_data_ok and s_req are 0 during reset. Data outputs are don't-care.
- State machine, 2 states:
  - IDLE: sel is chosen combinationally.
    - Only one req high: sel is that requester.
    - Both high: sel = rr_prio.
  - IDLE drive: s_req = (m0_req|m1_req) & ~full. s_* fields are muxed from sel.
  - IDLE transitions:
    - s_req & s_addr_ok: push sel, rr_prio <= ~sel, stay in IDLE (zero-cycle handshake).
    - s_req & ~s_addr_ok: latch owner <= sel, go to HOLD.
  - HOLD: s_req = req of owner; s_* are muxed from owner. The other requester is ignored.
    - On s_addr_ok: push owner, rr_prio <= ~owner, go to IDLE.
    - Owner drops req (protocol violation): return to IDLE without pushing.
- Address handshake: mX_addr_ok = s_addr_ok & s_req & (granted == X). It is never asserted for a non-granted requester.
- Full FIFO: when outstanding == DEPTH, s_req=0 in IDLE. A pop in the same cycle does not unblock; the new grant happens the next cycle.
- Full in HOLD: HOLD is entered only when not full, so HOLD never sees full.
- Response routing:
  - mX_data_ok = s_data_ok & ~empty & (head == X).
  - m0_rdata = m1_rdata = s_rdata (broadcast).
  - A valid s_data_ok pops the FIFO.
  - s_data_ok with empty FIFO sets resp_err; nothing is routed or popped.
- Counter: simultaneous push and pop in one cycle leaves outstanding unchanged. Pointers wrap modulo DEPTH.
- Latency: zero added cycles on both request and response paths. Everything is combinational through the muxes; only state, FIFO and rr_prio are registered.
- Reset mid-operation clears state, FIFO, counter and resp_err. Responses still in flight after reset count as resp_err only if they arrive after reset is released.

Test Plan:
- m0 read of 0x1000, s_addr_ok in the same cycle, s_data_ok 2 cycles later with rdata 0xDEADBEEF -> m0_addr_ok=1 at cycle 0; m0_data_ok=1 with 0xDEADBEEF at cycle 2; m1_data_ok stays 0; outstanding goes 1 then 0.
- m0 and m1 requesting continuously, s_addr_ok always 1 -> grants m0, m1, m0, m1; s_addr alternates between the two addresses.
- m1 granted, s_addr_ok held low 3 cycles while m0 requests -> s_addr stays m1's for 4 cycles; m1_addr_ok on cycle 3; m0 is granted next.
- DEPTH=4: accept 4 requests with no s_data_ok -> s_req=0 on the fifth; one s_data_ok -> s_req=1 the cycle after.
- Owner order m0, m1, m1, m0 accepted; four s_data_ok pulses -> data_ok to m0, m1, m1, m0 in that order; resp_err stays 0.
- Reset asserted during HOLD with 2 outstanding -> next cycle IDLE, outstanding=0. A subsequent s_data_ok sets resp_err=1 and gives no mX_data_ok.
